// File: rtl/double_div.sv
// double_div: iterative IEEE-754 binary64 divider, z = a / b.
//
// Restoring radix-2 division producing one quotient bit per clock, with
// full subnormal support and round-to-nearest-even. One operation is in
// flight at a time.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset (aborts any operation)
//   in_a      dividend, binary64
//   in_b      divisor, binary64
//   in_valid  operands valid
//   in_ready  divider idle and able to accept operands
//   out_z     quotient, binary64 (held stable while out_valid)
//   out_valid out_z valid
//   out_ready consumer accepts out_z
module double_div (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] in_a,
    input  logic [63:0] in_b,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] out_z,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam logic signed [12:0] EMIN = -13'sd1022;
    localparam logic signed [12:0] EMAX = 13'sd1023;
    localparam logic [63:0]        QNAN = 64'h7FF8_0000_0000_0000;

    typedef enum logic [3:0] {
        IDLE, UNPACK, SPECIAL, NORM_A, NORM_B, DIVIDE,
        NORM1, NORM2, ROUND, PACK, OUT
    } state_t;

    state_t state, state_nxt;

    logic [63:0]        a_r, b_r;
    logic               sign_r;
    logic signed [12:0] ea, eb, e;
    logic [52:0]        ma, mb;
    logic [53:0]        rem;
    logic [55:0]        q;
    logic               sticky;
    logic [5:0]         cnt;
    logic [52:0]        mant;

    // Special-case detection; returns {hit, result}. Priority order matters:
    // NaN-producing cases first, then infinities/zeros of a and b.
    function automatic logic [64:0] special_result(input logic [63:0] a,
                                                   input logic [63:0] b);
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
        a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
        b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
        a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 52'd0);
        b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 52'd0);
        a_zero = (a[62:0] == 63'd0);
        b_zero = (b[62:0] == 63'd0);
        s      = a[63] ^ b[63];
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero))
            return {1'b1, QNAN};
        else if (a_inf)
            return {1'b1, s, 11'h7FF, 52'd0};
        else if (b_inf)
            return {1'b1, s, 63'd0};
        else if (b_zero)
            return {1'b1, s, 11'h7FF, 52'd0};
        else if (a_zero)
            return {1'b1, s, 63'd0};
        else
            return {1'b0, 64'd0};
    endfunction

    // Round-to-nearest-even decision on the 56-bit quotient: mantissa is
    // q[55:3], guard q[2], round q[1], sticky q[0] plus accumulated sticky.
    function automatic logic round_up(input logic [55:0] qq, input logic st);
        return qq[2] & (qq[1] | qq[0] | st | qq[3]);
    endfunction

    // Assemble the final binary64 word from sign, unbiased exponent and
    // 53-bit mantissa. A clear hidden bit means subnormal or zero.
    function automatic logic [63:0] pack(input logic s,
                                         input logic signed [12:0] ex,
                                         input logic [52:0] m);
        logic [10:0] ebias;
        ebias = 11'(ex + 13'sd1023);
        if (ex > EMAX)
            return {s, 11'h7FF, 52'd0};
        else if (!m[52])
            return {s, 11'd0, m[51:0]};
        else
            return {s, ebias, m[51:0]};
    endfunction

    logic [64:0] spec_res;
    logic        rem_ge;
    logic [52:0] rem_sub;
    logic [53:0] mant_rnd;

    assign spec_res = special_result(a_r, b_r);
    assign rem_ge   = rem >= {1'b0, mb};
    // rem_sub < mb < 2^53 whenever it is used, so the top bit is dropped.
    assign rem_sub  = 53'(rem - {1'b0, mb});
    assign mant_rnd = {1'b0, q[55:3]} + 54'(round_up(q, sticky));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == OUT);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = UNPACK;
            UNPACK:  state_nxt = SPECIAL;
            SPECIAL: state_nxt = spec_res[64] ? OUT : NORM_A;
            NORM_A:  if (ma[52]) state_nxt = NORM_B;
            NORM_B:  if (mb[52]) state_nxt = DIVIDE;
            DIVIDE:  if (cnt == 6'd55) state_nxt = NORM1;
            NORM1:   state_nxt = NORM2;
            NORM2:   if (!(e < EMIN)) state_nxt = ROUND;
            ROUND:   state_nxt = PACK;
            PACK:    state_nxt = OUT;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath registers carry no reset; the FSM decides when they matter.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (in_valid) begin
                    a_r <= in_a;
                    b_r <= in_b;
                end
            end
            UNPACK: begin
                sign_r <= a_r[63] ^ b_r[63];
                ea <= (a_r[62:52] == 11'd0) ? EMIN
                                            : $signed({2'b00, a_r[62:52]}) - 13'sd1023;
                eb <= (b_r[62:52] == 11'd0) ? EMIN
                                            : $signed({2'b00, b_r[62:52]}) - 13'sd1023;
                ma <= {|a_r[62:52], a_r[51:0]};
                mb <= {|b_r[62:52], b_r[51:0]};
            end
            NORM_A: begin
                if (!ma[52]) begin
                    ma <= {ma[51:0], 1'b0};
                    ea <= ea - 13'sd1;
                end
            end
            NORM_B: begin
                if (!mb[52]) begin
                    mb <= {mb[51:0], 1'b0};
                    eb <= eb - 13'sd1;
                end else begin
                    rem <= {1'b0, ma};
                    q   <= 56'd0;
                    e   <= ea - eb;
                    cnt <= 6'd0;
                end
            end
            DIVIDE: begin
                if (rem_ge) begin
                    rem <= {rem_sub, 1'b0};
                    q   <= {q[54:0], 1'b1};
                end else begin
                    rem <= {rem[52:0], 1'b0};
                    q   <= {q[54:0], 1'b0};
                end
                cnt <= cnt + 6'd1;
            end
            NORM1: begin
                // Quotient of two [1,2) mantissas lies in (0.5,2): at most one shift.
                if (!q[55]) begin
                    q <= {q[54:0], 1'b0};
                    e <= e - 13'sd1;
                end
                sticky <= |rem;
            end
            NORM2: begin
                // Denormalise toward the minimum exponent, keeping lost bits sticky.
                if (e < EMIN) begin
                    q      <= {1'b0, q[55:1]};
                    sticky <= sticky | q[0];
                    e      <= e + 13'sd1;
                end
            end
            ROUND: begin
                if (mant_rnd[53]) begin
                    mant <= mant_rnd[53:1];
                    e    <= e + 13'sd1;
                end else begin
                    mant <= mant_rnd[52:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            out_z <= 64'd0;
        else if (state == SPECIAL && spec_res[64])
            out_z <= spec_res[63:0];
        else if (state == PACK)
            out_z <= pack(sign_r, e, mant);
    end

endmodule

// File: doc/double_div.md
Name: double_div

Overview:
- Iterative IEEE-754 binary64 divider, z = a / b, the inverse-operation companion to the double-precision multiplier in the math component library.
- Restoring radix-2 divide, one quotient bit per cycle, with valid/ready handshakes on both sides so it can sit in stream pipelines.
- Full denormal support and round-to-nearest-even.
- One operation in flight at a time.

Parameters:
- None. Format is fixed at binary64: 1 sign, 11 exponent, 52 fraction bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_a  input  64  dividend, binary64
- in_b  input  64  divisor, binary64
- in_valid  input  1  operands valid
- in_ready  output  1  divider idle and can accept operands
- out_z  output  64  quotient, binary64
- out_valid  output  1  out_z valid
- out_ready  input  1  consumer accepts out_z

Behaviour:
- Reset: one clock, synchronous, active-low. Sampled rst_n=0 gives out_valid=0, in_ready=1, out_z=0, state IDLE. Reset aborts any in-flight operation and discards it.
- Accept: a transfer occurs on an edge where in_valid & in_ready. in_a and in_b are latched, state goes to UNPACK, and in_ready drops on the next cycle.
- States:
  - IDLE: in_ready=1.
  - UNPACK (1 cycle): split the fields. Exponent is held as 13-bit signed and unbiased. A denormal gets exponent -1022 with the hidden bit 0; a normal number gets the hidden bit 1.
  - SPECIAL (1 cycle): if special, load out_z and go to OUT; otherwise go to NORM_A.
  - NORM_A / NORM_B: while mantissa bit52=0, shift left 1 and decrement exponent, one shift per cycle. The state occupies 1 cycle when already normalised.
  - DIVIDE: 56 cycles. The remainder register starts as mant_a, 54 bits wide. Each cycle, if rem >= mant_b, then rem -= mant_b and q bit=1; rem is then shifted left 1. Result exponent e = ea - eb.
  - NORM1 (1 cycle): if q[55]=0, shift q left 1 and e-=1.
  - NORM2: while e < -1022, shift q right 1 (OR-ing shifted-out bits into sticky) and e+=1, one cycle per shift, minimum 1 cycle. Final sticky = OR of shifted-out bits | (rem != 0).
  - ROUND (1 cycle): guard=q[2], round=q[1], sticky=q[0]|sticky. Round up when guard & (round | sticky | q[3]). A mantissa carry-out gives mant>>1 and e+=1.
  - PACK (1 cycle): e > 1023 gives signed infinity. If mant bit52=0 the result is denormal or zero, with biased exponent 0. Otherwise biased exponent = e+1023.
  - OUT: out_valid=1, out_z held stable until out_ready is sampled 1. On that edge out_valid goes to 0 and state returns to IDLE. There is no back-to-back acceptance in the same cycle: in_ready is asserted only in IDLE.
- Latency:
  - Normal operands with non-subnormal result: out_valid rises exactly 64 edges after the accept edge.
  - Special cases: 2 edges.
  - Denormal inputs add one cycle per normalising shift.
  - Subnormal results add (-1022 - e) cycles beyond 1 in NORM2.
- Specials, evaluated in priority order. Sign s = sa ^ sb.
  - a NaN, b NaN, inf/inf, or 0/0 gives canonical 0x7FF8000000000000.
  - a inf gives signed inf.
  - b inf gives signed zero.
  - b zero gives signed inf.
  - a zero gives signed zero.
- Input NaN payloads are not propagated.

Test Plan:
- 0x4018000000000000 / 0x4000000000000000 (6/2) -> out_z=0x4008000000000000, out_valid exactly 64 cycles after accept, in_ready low throughout. 0x3FF0000000000000 / 0x4008000000000000 (1/3) -> 0x3FD5555555555555.
- Specials, each with out_valid 2 cycles after accept:
  - 0x3FF0000000000000 / 0 -> 0x7FF0000000000000
  - 0xBFF0000000000000 / 0 -> 0xFFF0000000000000
  - 0/0 -> 0x7FF8000000000000
  - 0x7FF0000000000000 / 0x7FF0000000000000 -> 0x7FF8000000000000
  - 1.0 / inf -> 0x0000000000000000
- Denormals:
  - 0x0000000000000001 / 0x3FE0000000000000 -> 0x0000000000000002.
  - 0x0000000000000001 / 0x4000000000000000 -> 0x0000000000000000: exact tie, rounds to even.
  - 0x0000000000000003 / 0x4000000000000000 -> 0x0000000000000002: tie, rounds to even.
- Overflow: 0x7FEFFFFFFFFFFFFF / 0x3FE0000000000000 -> 0x7FF0000000000000.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_z and out_valid stable. in_valid asserted with new operands is ignored until the handshake completes, then accepted in IDLE.
- Reset during DIVIDE (rst_n=0 for one cycle, 30 cycles after accept) -> next cycle out_valid=0, in_ready=1, out_z=0. A subsequent 6/2 completes correctly in 64 cycles.
